ccx_mem_arbiter: RTL
====================

Name: ccx_mem_arbiter

Overview:
- Shares the single CCX external memory port between an instruction-fetch requester and a data requester.
- Drives the CCX-to-AXI4-Lite bridge downstream.
- Keeps exactly one transaction outstanding on the shared port, latches the winner's request fields, and routes the response handshake back to the owner.
- Sits in the core complex between the fetch/LSU memory ports and the bridge.

Parameters:
- AW, 39, address width.
- DW, 64, data width.

Ports:
- g_clk  in  1  core clock.
- g_reset  in  1  reset: asynchronous, active-high.
- imem_req  in  1  instruction read request; held until imem_gnt.
- imem_addr  in  AW  instruction request address.
- imem_gnt  out  1  instruction response handshake pulse.
- imem_err  out  1  instruction response error; valid the cycle after imem_gnt.
- imem_rdata  out  DW  instruction read data; valid the cycle after imem_gnt.
- dmem_req  in  1  data request; held until dmem_gnt.
- dmem_addr  in  AW  data request address.
- dmem_wen  in  1  data write enable.
- dmem_strb  in  8  data write byte strobe.
- dmem_wdata  in  DW  data write data.
- dmem_gnt  out  1  data response handshake pulse.
- dmem_err  out  1  data response error; valid the cycle after dmem_gnt.
- dmem_rdata  out  DW  data read data; valid the cycle after dmem_gnt.
- ccx_req  out  1  shared-port request, registered.
- ccx_rtype  out  1  request type: 0 = instruction, 1 = data.
- ccx_addr  out  AW  shared-port address.
- ccx_wen  out  1  shared-port write enable.
- ccx_strb  out  8  shared-port write strobe.
- ccx_wdata  out  DW  shared-port write data.
- ccx_gnt  in  1  shared-port response pulse.
- ccx_err  in  1  shared-port error; valid the cycle after ccx_gnt.
- ccx_rdata  in  DW  shared-port read data; valid the cycle after ccx_gnt.

Behaviour:
- Reset values (async on g_reset high):
  - state = IDLE; owner = 0; last_owner = 0.
  - ccx_req, ccx_rtype, ccx_wen = 0; ccx_addr, ccx_strb, ccx_wdata = 0.
  - imem_gnt and dmem_gnt are combinational, so they are 0 while in reset.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any request is present, pick a winner and register its fields into ccx_*.
  - Set ccx_req = 1, record owner and last_owner, go to BUSY.
  - Latency: request sampled at cycle t gives ccx_req high at t+1.
- Instruction winner fields: ccx_rtype = 0, ccx_wen = 0, ccx_strb = 0, ccx_wdata = 0, ccx_addr = imem_addr.
- Data winner fields: ccx_rtype = 1; dmem_* copied to ccx_*.
- Default priority with both requesting in the same cycle: data wins.
- BUSY:
  - ccx_* are held stable.
  - On ccx_gnt: ccx_req <= 0, state <= IDLE.
  - The owner's gnt = ccx_gnt, combinational, same cycle. The other port's gnt stays 0.
- Response data: imem_rdata, dmem_rdata, imem_err and dmem_err are driven directly from ccx_rdata/ccx_err. Only the gnt pulse is qualified by owner.
- Back-to-back transactions:
  - ccx_req is low for exactly one cycle (the IDLE cycle) after each ccx_gnt.
  - This satisfies the bridge, which reissues if ccx_req is still high after a response.
  - Minimum issue interval is 2 cycles after each gnt.
- Requester rules:
  - req and its fields stay stable until the corresponding gnt.
  - A requester may drop or re-raise req from the cycle after its gnt.
  - Fields change in BUSY for a non-owner port are ignored.
  - Requests arriving in BUSY wait; none are dropped.
- Stray ccx_gnt while in IDLE: ignored; no upstream gnt is produced.
- Reset mid-transaction: FSM returns to IDLE and ccx_req drops immediately. The downstream bridge is reset in the same domain; no response is forwarded after reset.

Optional Feature:
- Macro: CCX_ARB_RR_EN.
- Defined: when both ports request in IDLE, the port not equal to last_owner wins (round-robin). A single requester always wins.
- Undefined: fixed data-over-instruction priority. last_owner is still registered but unused.

Decomposition:
- Shared package ccx_arb_pkg:
  - owner encodings OWN_INSTR = 0, OWN_DATA = 1;
  - state encodings ST_IDLE, ST_BUSY;
  - default AW/DW.
- One small sub-module, ccx_arb_pick:
  - combinational winner select from imem_req, dmem_req and last_owner;
  - contains the CCX_ARB_RR_EN ifdef.

Test Plan:
- Reset while BUSY with ccx_req = 1 → ccx_req = 0 asynchronously, state IDLE. Next imem_req is issued normally.
- Lone imem_req, addr = 0x0000001000 → ccx_req at t+1, ccx_rtype = 0, ccx_wen = 0. ccx_gnt at t+4 with ccx_rdata = 0xDEADBEEF_CAFEF00D → imem_gnt at t+4 only; imem_rdata shows the value at t+5.
- Lone dmem write, addr = 0x40, strb = 0x0F, wdata = 0x11223344 → ccx_wen = 1, ccx_rtype = 1, fields match; dmem_gnt on ccx_gnt; imem_gnt stays 0.
- imem_req and dmem_req in the same cycle (RR disabled) → data issued first. After its gnt, ccx_req low for 1 cycle, then the instruction is issued.
- Both ports requesting continuously with CCX_ARB_RR_EN → grants alternate D, I, D, I over 4 transactions. Without the macro → D, D, D, D while dmem_req is held.
- ccx_gnt pulse while IDLE; ccx_err = 1 on a data read → no upstream gnt for the stray pulse; on a real data transaction, dmem_err = 1 the cycle after dmem_gnt.

Source files
------------

// File: rtl/ccx_arb_pkg.sv
// Shared definitions for the CCX memory arbiter: owner and state encodings
// and the default shared-port geometry.
package ccx_arb_pkg;

  localparam int unsigned CCX_AW = 39;
  localparam int unsigned CCX_DW = 64;
  localparam int unsigned CCX_SW = 8;

  // Owner of the shared port; also the value driven on ccx_rtype
  localparam logic OWN_INSTR = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ccx_arb_pick.sv
// Combinational winner select for the CCX memory arbiter.
// Build option: CCX_ARB_RR_EN selects round-robin between the two ports when
// both request; otherwise data always beats instruction.
module ccx_arb_pick
  import ccx_arb_pkg::*;
(
  input  logic imem_req,
  input  logic dmem_req,
  input  logic last_owner,
  output logic any_req,
  output logic winner
);

  assign any_req = imem_req | dmem_req;

`ifdef CCX_ARB_RR_EN
  // Contended cycles go to the port that did not win last time
  always_comb begin
    winner = OWN_INSTR;
    if (imem_req && dmem_req) begin
      winner = ~last_owner;
    end else if (dmem_req) begin
      winner = OWN_DATA;
    end
  end
`else
  // last_owner only matters for round-robin builds
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  // Fixed priority: data over instruction
  always_comb begin
    winner = dmem_req ? OWN_DATA : OWN_INSTR;
  end
`endif

endmodule

// File: rtl/ccx_mem_arbiter.sv
// Shares the single CCX memory port between instruction fetch and data
// requesters. One transaction outstanding at a time; the winner's request
// fields are registered onto ccx_* and the response pulse is steered back to
// the owner. Build option: CCX_ARB_RR_EN (round-robin arbitration, see
// ccx_arb_pick).
module ccx_mem_arbiter
  import ccx_arb_pkg::*;
#(
  parameter int unsigned AW = CCX_AW,
  parameter int unsigned DW = CCX_DW
) (
  input  logic              g_clk,
  input  logic              g_reset,
  // Instruction requester
  input  logic              imem_req,
  input  logic [AW-1:0]     imem_addr,
  output logic              imem_gnt,
  output logic              imem_err,
  output logic [DW-1:0]     imem_rdata,
  // Data requester
  input  logic              dmem_req,
  input  logic [AW-1:0]     dmem_addr,
  input  logic              dmem_wen,
  input  logic [CCX_SW-1:0] dmem_strb,
  input  logic [DW-1:0]     dmem_wdata,
  output logic              dmem_gnt,
  output logic              dmem_err,
  output logic [DW-1:0]     dmem_rdata,
  // Shared port towards the CCX-to-AXI4-Lite bridge
  output logic              ccx_req,
  output logic              ccx_rtype,
  output logic [AW-1:0]     ccx_addr,
  output logic              ccx_wen,
  output logic [CCX_SW-1:0] ccx_strb,
  output logic [DW-1:0]     ccx_wdata,
  input  logic              ccx_gnt,
  input  logic              ccx_err,
  input  logic [DW-1:0]     ccx_rdata
);

  arb_state_e state_q;
  logic       owner_q;
  logic       last_owner_q;
  logic       any_req;
  logic       winner;

  ccx_arb_pick u_pick (
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .last_owner (last_owner_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  // Issue FSM; ccx_* are registered and only change when leaving IDLE
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INSTR;
      last_owner_q <= OWN_INSTR;
      ccx_req      <= 1'b0;
      ccx_rtype    <= 1'b0;
      ccx_addr     <= '0;
      ccx_wen      <= 1'b0;
      ccx_strb     <= '0;
      ccx_wdata    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A stray ccx_gnt here is ignored by construction
          if (any_req) begin
            ccx_req      <= 1'b1;
            owner_q      <= winner;
            last_owner_q <= winner;
            state_q      <= ST_BUSY;
            if (winner == OWN_DATA) begin
              ccx_rtype <= OWN_DATA;
              ccx_addr  <= dmem_addr;
              ccx_wen   <= dmem_wen;
              ccx_strb  <= dmem_strb;
              ccx_wdata <= dmem_wdata;
            end else begin
              ccx_rtype <= OWN_INSTR;
              ccx_addr  <= imem_addr;
              ccx_wen   <= 1'b0;
              ccx_strb  <= '0;
              ccx_wdata <= '0;
            end
          end
        end
        ST_BUSY: begin
          // Dropping ccx_req for the IDLE cycle keeps the bridge from reissuing
          if (ccx_gnt) begin
            ccx_req <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Response pulse goes only to the current owner; data/err are shared wires
  assign imem_gnt   = (state_q == ST_BUSY) && ccx_gnt && (owner_q == OWN_INSTR);
  assign dmem_gnt   = (state_q == ST_BUSY) && ccx_gnt && (owner_q == OWN_DATA);
  assign imem_err   = ccx_err;
  assign dmem_err   = ccx_err;
  assign imem_rdata = ccx_rdata;
  assign dmem_rdata = ccx_rdata;

endmodule
